// File: rtl/madd_fir_seq_if.sv
// rtl/madd_fir_seq_if.sv - bus bundle between the FIR sequencer, its RAMs and the multiply-add core
//
// Purpose: groups the start/configuration inputs, the sample and coefficient
// read ports, the multiply-add core port and the result outputs of
// madd_fir_seq into one bundle.
//
// Signals:
//   start, num_pairs, base_addr, sub_mode   pass request and its configuration
//   smp_addr0/1, smp_rdata0/1               sample RAM read ports (1-cycle read)
//   coef_addr0/1, coef_rdata0/1             coefficient RAM read ports (1-cycle read)
//   ma_ce, ma_a0/a1/b0/b1, ma_addsub, ma_p  multiply-add core operands and result
//   y, y_valid, sat, busy                   filtered sample and pass status
//
// Modports:
//   master  the sequencer (madd_fir_seq)
//   slave   everything around it (RAMs, core, pass requester)

interface madd_fir_seq_if #(
    parameter int ADDR_W = 10,
    parameter int NUM_W  = 9
);
    logic              start;
    logic [NUM_W-1:0]  num_pairs;
    logic [ADDR_W-1:0] base_addr;
    logic              sub_mode;

    logic [ADDR_W-1:0] smp_addr0;
    logic [ADDR_W-1:0] smp_addr1;
    logic [15:0]       smp_rdata0;
    logic [15:0]       smp_rdata1;
    logic [ADDR_W-1:0] coef_addr0;
    logic [ADDR_W-1:0] coef_addr1;
    logic [15:0]       coef_rdata0;
    logic [15:0]       coef_rdata1;

    logic              ma_ce;
    logic [15:0]       ma_a0;
    logic [15:0]       ma_a1;
    logic [15:0]       ma_b0;
    logic [15:0]       ma_b1;
    logic              ma_addsub;
    logic [32:0]       ma_p;

    logic [15:0]       y;
    logic              y_valid;
    logic              sat;
    logic              busy;

    modport master (
        input  start, num_pairs, base_addr, sub_mode,
        input  smp_rdata0, smp_rdata1, coef_rdata0, coef_rdata1,
        input  ma_p,
        output smp_addr0, smp_addr1, coef_addr0, coef_addr1,
        output ma_ce, ma_a0, ma_a1, ma_b0, ma_b1, ma_addsub,
        output y, y_valid, sat, busy
    );

    modport slave (
        output start, num_pairs, base_addr, sub_mode,
        output smp_rdata0, smp_rdata1, coef_rdata0, coef_rdata1,
        output ma_p,
        input  smp_addr0, smp_addr1, coef_addr0, coef_addr1,
        input  ma_ce, ma_a0, ma_a1, ma_b0, ma_b1, ma_addsub,
        input  y, y_valid, sat, busy
    );
endinterface

// File: rtl/madd_fir_seq.sv
// rtl/madd_fir_seq.sv - two-taps-per-cycle FIR sequencer around a dual-product multiply-add core
//
// Purpose: on start, walks the circular sample buffer backwards from
// base_addr and the coefficient memory forwards from 0, two taps per cycle,
// feeds operand pairs to the multiply-add core, accumulates the core results
// and produces one rounded, shifted and saturated 16-bit output sample.
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset; aborts any pass in flight
//   bus   madd_fir_seq_if.master:
//           start/num_pairs/base_addr/sub_mode   pass request (sampled at start)
//           smp_*/coef_*                         RAM read ports, 1-cycle read latency
//           ma_*                                 multiply-add core, MA_LAT result latency
//           y/y_valid/sat/busy                   result and status

module madd_fir_seq #(
    parameter int ADDR_W = 10,
    parameter int NUM_W  = 9,
    parameter int MA_LAT = 2,
    parameter int ACC_W  = 40,
    parameter int SHIFT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    madd_fir_seq_if.master    bus
);

    // address register -> RAM read -> operand register -> MA_LAT core stages
    localparam int D = 2 + MA_LAT;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FINAL = 2'd3;

    localparam logic signed [ACC_W:0] RND =
        (ACC_W+1)'((SHIFT == 0) ? 0 : (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)));
    localparam logic signed [ACC_W:0] Y_MAX = (ACC_W+1)'(32767);
    localparam logic signed [ACC_W:0] Y_MIN = (ACC_W+1)'(-32768);

    logic [1:0]               r_state;
    logic [NUM_W-1:0]         r_cnt;
    logic                     r_sub;
    logic [D-1:0]             r_tag;
    logic signed [ACC_W-1:0]  r_acc;

    logic [ADDR_W-1:0]        r_smp_addr0;
    logic [ADDR_W-1:0]        r_smp_addr1;
    logic [ADDR_W-1:0]        r_coef_addr0;
    logic [ADDR_W-1:0]        r_coef_addr1;

    logic [15:0]              r_ma_a0;
    logic [15:0]              r_ma_a1;
    logic [15:0]              r_ma_b0;
    logic [15:0]              r_ma_b1;

    logic [15:0]              r_y;
    logic                     r_y_valid;
    logic                     r_sat;
    logic                     r_busy;

    logic signed [ACC_W-1:0]  w_p_ext;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W:0]    w_rnd;
    logic signed [ACC_W:0]    w_r;
    logic                     w_sat_hi;
    logic                     w_sat_lo;
    logic [15:0]              w_y;
    logic                     w_issue;
    logic                     w_drain_done;

    assign w_issue = (r_state == S_ISSUE);

    // The tag leaving the last stage marks the cycle the core result for a
    // pair is on ma_p.
    assign w_p_ext    = ACC_W'($signed(bus.ma_p));
    assign w_acc_next = r_tag[D-1] ? (r_acc + w_p_ext) : r_acc;

    // The result is formed from w_acc_next so that the final accumulation and
    // the output register load share one edge; this keeps y_valid one cycle
    // after the last accumulation.
    assign w_rnd    = (ACC_W+1)'(w_acc_next) + RND;
    assign w_r      = w_rnd >>> SHIFT;
    assign w_sat_hi = (w_r > Y_MAX);
    assign w_sat_lo = (w_r < Y_MIN);
    assign w_y      = w_sat_hi ? 16'h7fff : (w_sat_lo ? 16'h8000 : w_r[15:0]);

    // Only the last stage may still be occupied: its accumulation happens on
    // the same edge that leaves DRAIN.
    assign w_drain_done = (r_tag[D-2:0] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_sub        <= 1'b0;
            r_tag        <= '0;
            r_acc        <= '0;
            r_smp_addr0  <= '0;
            r_smp_addr1  <= '0;
            r_coef_addr0 <= '0;
            r_coef_addr1 <= '0;
            r_ma_a0      <= '0;
            r_ma_a1      <= '0;
            r_ma_b0      <= '0;
            r_ma_b1      <= '0;
            r_y          <= '0;
            r_y_valid    <= 1'b0;
            r_sat        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_tag     <= {r_tag[D-2:0], w_issue};
            r_ma_a0   <= bus.smp_rdata0;
            r_ma_b0   <= bus.coef_rdata0;
            r_ma_a1   <= bus.smp_rdata1;
            r_ma_b1   <= bus.coef_rdata1;
            r_y_valid <= 1'b0;

            if (r_tag[D-1]) begin
                r_acc <= w_acc_next;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sub        <= bus.sub_mode;
                        r_cnt        <= bus.num_pairs;
                        r_acc        <= '0;
                        r_busy       <= 1'b1;
                        r_smp_addr0  <= bus.base_addr;
                        r_smp_addr1  <= bus.base_addr - ADDR_W'(1);
                        r_coef_addr0 <= '0;
                        r_coef_addr1 <= ADDR_W'(1);
                        if (bus.num_pairs == '0) begin
                            // empty filter: rounding of zero is zero
                            r_state   <= S_FINAL;
                            r_y       <= '0;
                            r_sat     <= 1'b0;
                            r_y_valid <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    r_smp_addr0  <= r_smp_addr0 - ADDR_W'(2);
                    r_smp_addr1  <= r_smp_addr1 - ADDR_W'(2);
                    r_coef_addr0 <= r_coef_addr0 + ADDR_W'(2);
                    r_coef_addr1 <= r_coef_addr1 + ADDR_W'(2);
                    r_cnt        <= r_cnt - NUM_W'(1);
                    if (r_cnt == NUM_W'(1)) begin
                        r_state <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (w_drain_done) begin
                        r_state   <= S_FINAL;
                        r_y       <= w_y;
                        r_sat     <= w_sat_hi | w_sat_lo;
                        r_y_valid <= 1'b1;
                    end
                end

                default: begin
                    // S_FINAL: y_valid is high this cycle; start is ignored here
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.smp_addr0  = r_smp_addr0;
    assign bus.smp_addr1  = r_smp_addr1;
    assign bus.coef_addr0 = r_coef_addr0;
    assign bus.coef_addr1 = r_coef_addr1;
    assign bus.ma_ce      = r_busy;
    assign bus.ma_a0      = r_ma_a0;
    assign bus.ma_a1      = r_ma_a1;
    assign bus.ma_b0      = r_ma_b0;
    assign bus.ma_b1      = r_ma_b1;
    assign bus.ma_addsub  = r_sub;
    assign bus.y          = r_y;
    assign bus.y_valid    = r_y_valid;
    assign bus.sat        = r_sat;
    assign bus.busy       = r_busy;

endmodule
